// File: rtl/par_tx_logic.sv
// Transmit side of the parallel inter-router link: pops a FWFT FIFO into a two-deep
// output/skid buffer and drives items with valid/busy. Optional counter: PAR_TX_STATS_EN.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module par_tx_logic #(
    parameter int CNT_W = 16,
    localparam int W = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     item_in,
    input  logic             empty,
    output logic             read,
    output logic [W-1:0]     item_out,
    output logic             valid,
    input  logic             busy,
    output logic             idle
`ifdef PAR_TX_STATS_EN
    ,
    output logic [CNT_W-1:0] sent_cnt
`endif
);

    // Handshake: an item crosses the link on every cycle where valid=1 and busy=0;
    // valid and item_out hold while busy=1. read pops the FIFO at the same edge.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   out_q;
    logic [W-1:0]   skid_q;
    logic           valid_q;
    logic           xfer;

    // Read depends only on registered state, never on busy.
    assign read     = !rst && !empty && (state_q != TWO);
    assign xfer     = valid_q && !busy;
    assign item_out = out_q;
    assign valid    = valid_q;
    assign idle     = (state_q == EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (read) begin
                        out_q   <= item_in;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (read && xfer) begin
                        out_q <= item_in;
                    end else if (read) begin
                        skid_q  <= item_in;
                        state_q <= TWO;
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        out_q   <= skid_q;
                        skid_q  <= '0;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PAR_TX_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d    = xfer ? cnt_q + 1'b1 : cnt_q;
    assign sent_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
